freq_gate_ctrl: RTL and testbench

Measurement sequencer for the frequency counter path. Generates a gate window of programmable length in system-clock cycles and counts rising edges of an asynchronous input during that window. Publishes each result through a valid/ack handshake. Runs single-shot or back-to-back, and supports abort, saturation and overrun reporting. It replaces free-running gate logic so that the gate and count are sequenced from one clock.

---
 rtl/freq_gate_ctrl.sv | 154 +++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Gate-window frequency counter: counts synchronized rising edges of an async input
// over a programmable number of clk cycles and publishes the result via valid/ack.
module freq_gate_ctrl #(
  parameter int CNT_W       = 40,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_signal,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  output logic              period,
  output logic              busy,
  output logic [CNT_W-1:0]  counter_out,
  output logic              count_valid,
  input  logic              count_ack,
  output logic              overflow,
  output logic              overrun,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_GAP} state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_syncPrev;
  logic [GATE_W-1:0]       r_lenQ;
  logic [GATE_W-1:0]       r_gateCnt;
  logic [CNT_W-1:0]        r_edgeCnt;
  logic                    r_period;
  logic                    r_busy;
  logic [CNT_W-1:0]        r_counterOut;
  logic                    r_countValid;
  logic                    r_overflow;
  logic                    r_overrun;
  logic                    r_cfgErr;

  logic                    w_edge;
  logic [CNT_W-1:0]        w_edgeNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_syncPrev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], input_signal};
      r_syncPrev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Saturating edge count including an edge arriving in the current cycle.
  always_comb begin
    w_edge     = r_sync[SYNC_STAGES-1] & ~r_syncPrev;
    w_edgeNext = r_edgeCnt;
    if (w_edge && (r_edgeCnt != CNT_MAX)) begin
      w_edgeNext = r_edgeCnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lenQ       <= '0;
      r_gateCnt    <= '0;
      r_edgeCnt    <= '0;
      r_period     <= 1'b0;
      r_busy       <= 1'b0;
      r_counterOut <= '0;
      r_countValid <= 1'b0;
      r_overflow   <= 1'b0;
      r_overrun    <= 1'b0;
      r_cfgErr     <= 1'b0;
    end else begin
      if (count_ack) begin
        r_countValid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (gate_len == '0) begin
              r_cfgErr <= 1'b1;
            end else begin
              r_lenQ    <= gate_len;
              r_gateCnt <= gate_len - GATE_ONE;
              r_edgeCnt <= '0;
              r_cfgErr  <= 1'b0;
              r_overrun <= 1'b0;
              r_period  <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_GATE;
            end
          end
        end
        S_GATE: begin
          if (abort) begin
            r_period <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_gateCnt == '0) begin
            // Publish overrides a same-cycle ack; overrun only if the old result was never taken.
            r_counterOut <= w_edgeNext;
            r_overflow   <= (w_edgeNext == CNT_MAX);
            r_countValid <= 1'b1;
            if (r_countValid && !count_ack) begin
              r_overrun <= 1'b1;
            end
            r_period <= 1'b0;
            if (continuous) begin
              r_state <= S_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_edgeCnt <= w_edgeNext;
            r_gateCnt <= r_gateCnt - GATE_ONE;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gateCnt <= r_lenQ - GATE_ONE;
            r_edgeCnt <= '0;
            r_period  <= 1'b1;
            r_state   <= S_GATE;
          end
        end
        default: begin
          r_period <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign period      = r_period;
  assign busy        = r_busy;
  assign counter_out = r_counterOut;
  assign count_valid = r_countValid;
  assign overflow    = r_overflow;
  assign overrun     = r_overrun;
  assign cfg_err     = r_cfgErr;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: directed corner cases, then randomized gates checked by a
// scoreboard whose expected counts come from the recorded input edge times.
module tb_freq_gate_ctrl;

  localparam int CNT_W  = 6;
  localparam int GATE_W = 12;
  localparam int SYNC   = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              input_signal;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              period;
  logic              busy;
  logic [CNT_W-1:0]  counter_out;
  logic              count_valid;
  logic              count_ack;
  logic              overflow;
  logic              overrun;
  logic              cfg_err;

  logic ackDrv;
  logic monAck;
  logic monEnable;
  assign count_ack = monEnable ? monAck : ackDrv;

  int tests;
  int errors;
  int cyc;
  int edgeCyc[$];
  int sb[$];
  int genMode;
  int fixHi;
  int fixLo;
  int hiLeft;
  int loLeft;

  freq_gate_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .input_signal(input_signal), .start(start),
    .continuous(continuous), .abort(abort), .gate_len(gate_len), .period(period),
    .busy(busy), .counter_out(counter_out), .count_valid(count_valid),
    .count_ack(count_ack), .overflow(overflow), .overrun(overrun), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Boundary edges may land on either side of the gate, so counts get +-1 slack.
  task automatic checkNear(input string name, input int act, input int raw);
    int lo;
    int hi;
    lo = (raw > 0) ? raw - 1 : 0;
    hi = raw + 1;
    if (lo > MAXC) lo = MAXC;
    if (hi > MAXC) hi = MAXC;
    tests++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic checkOverflow(input string name, input int act, input int raw);
    if (raw - 1 >= MAXC) checkOutput(name, act, 1);
    else if (raw + 1 < MAXC) checkOutput(name, act, 0);
  endtask

  // Edges seen by the gate opening after cycle c: detected SYNC cycles after being driven.
  function automatic int expCount(input int c, input int len);
    int n;
    n = 0;
    foreach (edgeCyc[i]) begin
      if (edgeCyc[i] + SYNC >= c + 1 && edgeCyc[i] + SYNC <= c + len) n++;
    end
    return n;
  endfunction

  // One clock cycle: advance at negedge, drive the input waveform, clear pulse inputs.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    start  = 1'b0;
    abort  = 1'b0;
    ackDrv = 1'b0;
    if (genMode == 0) begin
      input_signal = 1'b0;
    end else if (input_signal) begin
      hiLeft--;
      if (hiLeft <= 0) begin
        input_signal = 1'b0;
        loLeft = (genMode == 1) ? int'($urandom_range(1, 8)) : fixLo;
      end
    end else begin
      loLeft--;
      if (loLeft <= 0) begin
        input_signal = 1'b1;
        edgeCyc.push_back(cyc);
        hiLeft = (genMode == 1) ? int'($urandom_range(1, 4)) : fixHi;
      end
    end
  endtask

  task automatic runTo(input int target);
    while (cyc < target) applyStimulus();
  endtask

  task automatic startGate(input int len, input logic cont, output int c);
    applyStimulus();
    start      = 1'b1;
    gate_len   = GATE_W'(len);
    continuous = cont;
    c = cyc;
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_period"}, int'(period), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_counter_out"}, int'(counter_out), 0);
    checkOutput({tag, "_count_valid"}, int'(count_valid), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
    checkOutput({tag, "_overrun"}, int'(overrun), 0);
    checkOutput({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  // Scoreboard monitor: every new result is compared against the oldest expectation, then acked.
  initial begin
    int raw;
    monAck = 1'b0;
    forever begin
      @(negedge clk);
      if (!monEnable) begin
        monAck = 1'b0;
      end else if (monAck) begin
        monAck = 1'b0;
      end else if (count_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          raw = sb.pop_front();
          checkNear("sb_count", int'(counter_out), raw);
          checkOverflow("sb_overflow", int'(overflow), raw);
          checkOutput("sb_overrun", int'(overrun), 0);
        end
        monAck = 1'b1;
      end
    end
  end

  initial begin
    int c;
    int len;
    int gates;
    int total;
    int off;
    tests = 0; errors = 0; cyc = 0;
    genMode = 0; fixHi = 1; fixLo = 1; hiLeft = 0; loLeft = 0;
    monEnable = 1'b0; ackDrv = 1'b0;
    rst = 1'b1; input_signal = 1'b0; start = 1'b0; continuous = 1'b0;
    abort = 1'b0; gate_len = '0;
    repeat (3) applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkAllReset("reset");

    start = 1'b1;
    gate_len = '0;
    applyStimulus();
    checkOutput("cfg_err_set", int'(cfg_err), 1);
    checkOutput("cfg_err_busy", int'(busy), 0);
    checkOutput("cfg_err_period", int'(period), 0);

    // A second start mid-gate must not change the gate length.
    genMode = 1;
    startGate(20, 1'b0, c);
    applyStimulus();
    checkOutput("start_clears_cfg_err", int'(cfg_err), 0);
    checkOutput("gate_busy", int'(busy), 1);
    checkOutput("gate_period", int'(period), 1);
    runTo(c + 5);
    start = 1'b1;
    gate_len = GATE_W'(5);
    runTo(c + 20);
    checkOutput("ignored_start_period", int'(period), 1);
    checkOutput("ignored_start_valid", int'(count_valid), 0);
    applyStimulus();
    checkOutput("single_valid", int'(count_valid), 1);
    checkOutput("single_period_low", int'(period), 0);
    checkOutput("single_busy_low", int'(busy), 0);
    checkNear("single_count", int'(counter_out), expCount(c, 20));
    ackDrv = 1'b1;
    applyStimulus();
    checkOutput("ack_clears_valid", int'(count_valid), 0);

    // Continuous: ack coinciding with the 2nd publish, then an unacked 3rd publish.
    startGate(10, 1'b1, c);
    runTo(c + 11);
    checkOutput("cont_valid1", int'(count_valid), 1);
    checkNear("cont_count1", int'(counter_out), expCount(c, 10));
    runTo(c + 21);
    ackDrv = 1'b1;
    applyStimulus();
    checkOutput("corner_valid", int'(count_valid), 1);
    checkOutput("corner_overrun", int'(overrun), 0);
    checkOutput("gap_period", int'(period), 0);
    checkOutput("gap_busy", int'(busy), 1);
    checkNear("corner_count", int'(counter_out), expCount(c + 11, 10));
    applyStimulus();
    checkOutput("after_gap_period", int'(period), 1);
    continuous = 1'b0;
    runTo(c + 33);
    checkOutput("overrun_set", int'(overrun), 1);
    checkOutput("overrun_valid", int'(count_valid), 1);
    checkOutput("overrun_busy", int'(busy), 0);
    checkNear("overrun_count", int'(counter_out), expCount(c + 22, 10));
    ackDrv = 1'b1;
    applyStimulus();
    checkOutput("overrun_ack_valid", int'(count_valid), 0);
    checkOutput("overrun_sticky", int'(overrun), 1);

    genMode = 2; fixHi = 1; fixLo = 2;
    startGate(300, 1'b0, c);
    runTo(c + 301);
    checkOutput("sat_count", int'(counter_out), MAXC);
    checkOutput("sat_overflow", int'(overflow), 1);
    checkOutput("sat_overrun_cleared", int'(overrun), 0);
    ackDrv = 1'b1;
    applyStimulus();

    genMode = 2; fixHi = 5; fixLo = 5;
    startGate(100, 1'b0, c);
    runTo(c + 50);
    abort = 1'b1;
    applyStimulus();
    checkOutput("abort_period", int'(period), 0);
    checkOutput("abort_busy", int'(busy), 0);
    runTo(c + 110);
    checkOutput("abort_no_valid", int'(count_valid), 0);
    checkOutput("abort_counter_kept", int'(counter_out), MAXC);
    checkOutput("abort_overflow_kept", int'(overflow), 1);

    startGate(50, 1'b0, c);
    runTo(c + 20);
    #2 rst = 1'b1;
    #1 checkAllReset("async_reset");
    applyStimulus();
    rst = 1'b0;
    genMode = 0;
    repeat (5) applyStimulus();
    edgeCyc.delete();

    // Randomized gates: per-cycle period/busy checks here, results via the scoreboard monitor.
    monEnable = 1'b1;
    genMode = 1;
    for (int run = 0; run < 25; run++) begin
      while (edgeCyc.size() > 0 && edgeCyc[0] < cyc - 10) void'(edgeCyc.pop_front());
      len   = int'($urandom_range(3, 120));
      gates = int'($urandom_range(1, 3));
      startGate(len, gates > 1, c);
      total = c + (gates - 1) * (len + 1) + len;
      while (cyc < total + 3 + int'($urandom_range(0, 4))) begin
        applyStimulus();
        gate_len   = GATE_W'($urandom_range(0, 200));
        continuous = (gates > 1) && (cyc <= c + (gates - 1) * (len + 1));
        if (cyc <= total) start = ($urandom_range(0, 15) == 0);
        off = cyc - c - 1;
        checkOutput("rand_period", int'(period),
                    (off / (len + 1) < gates && off % (len + 1) < len) ? 1 : 0);
        checkOutput("rand_busy", int'(busy), (cyc <= total) ? 1 : 0);
        if (off % (len + 1) == len - 1 && off / (len + 1) < gates) begin
          sb.push_back(expCount(c + (off / (len + 1)) * (len + 1), len));
        end
      end
      checkOutput("sb_drained", sb.size(), 0);
    end
    monEnable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
